// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and pipeline-register indices for the hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_WAIT,
    HZ_PEND
  } hz_state_e;

  localparam int PREG_IF_ID  = 0;
  localparam int PREG_ID_EX  = 1;
  localparam int PREG_EX_MEM = 2;
  localparam int PREG_MEM_WB = 3;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-controller signal bundle: decode/branch/memory status in, pipeline controls out.
interface hazard_ctrl_unit_if #(
  parameter int NUM_PREG = 4,
  parameter int REG_AW   = 5,
  parameter int PC_W     = 32,
  parameter int CNT_W    = 16
);
  logic [REG_AW-1:0]   id_rs1_i;
  logic [REG_AW-1:0]   id_rs2_i;
  logic                id_use_rs1_i;
  logic                id_use_rs2_i;
  logic [REG_AW-1:0]   ex_rd_i;
  logic                ex_mem_rd_i;
  logic                redirect_i;
  logic [PC_W-1:0]     redirect_tgt_i;
  logic                im_wait_i;
  logic                dm_wait_i;
  logic                pc_stall_o;
  logic                pc_redirect_o;
  logic [PC_W-1:0]     pc_tgt_o;
  logic [NUM_PREG-1:0] stall_o;
  logic [NUM_PREG-1:0] flush_o;
  logic                timeout_o;
  logic [CNT_W-1:0]    stall_cnt_o;
  logic [CNT_W-1:0]    flush_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_rd_i, ex_mem_rd_i,
           redirect_i, redirect_tgt_i, im_wait_i, dm_wait_i,
    input  pc_stall_o, pc_redirect_o, pc_tgt_o, stall_o, flush_o, timeout_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_rd_i, ex_mem_rd_i,
           redirect_i, redirect_tgt_i, im_wait_i, dm_wait_i,
    output pc_stall_o, pc_redirect_o, pc_tgt_o, stall_o, flush_o, timeout_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, memory-wait freeze, deferred redirects,
// wait watchdog and saturating stall/flush counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int NUM_PREG = 4,
  parameter int REG_AW   = 5,
  parameter int PC_W     = 32,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 255
) (
  input logic               clk,
  input logic               rst_n,
  hazard_ctrl_unit_if.slave hz
);
  localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  hz_state_e           state_q, state_d;
  logic [PC_W-1:0]     pend_tgt_q, pend_tgt_d;
  logic                timeout_q, timeout_d;
  logic [WAIT_W-1:0]   wait_cnt;

  logic                mem_busy, load_use, run_rules;
  logic                pc_stall, pc_redirect;
  logic [PC_W-1:0]     pc_tgt;
  logic [NUM_PREG-1:0] stall, flush;

  assign mem_busy = hz.im_wait_i | hz.dm_wait_i;
  assign load_use = hz.ex_mem_rd_i & (hz.ex_rd_i != REG_ZERO) &
                    ((hz.id_use_rs1_i & (hz.id_rs1_i == hz.ex_rd_i)) |
                     (hz.id_use_rs2_i & (hz.id_rs2_i == hz.ex_rd_i)));

  always_comb begin
    state_d     = state_q;
    pend_tgt_d  = pend_tgt_q;
    pc_stall    = 1'b0;
    pc_redirect = 1'b0;
    pc_tgt      = hz.redirect_tgt_i;
    stall       = '0;
    flush       = '0;
    run_rules   = 1'b0;

    // WAIT shares the RUN rules: still busy keeps the freeze, not busy falls straight through.
    case (state_q)
      HZ_RUN, HZ_WAIT: run_rules = 1'b1;
      HZ_PEND: begin
        pc_tgt = pend_tgt_q;
        if (mem_busy) begin
          pc_stall = 1'b1;
          stall    = '1;
        end else begin
          pc_redirect       = 1'b1;
          flush[PREG_IF_ID] = 1'b1;
          flush[PREG_ID_EX] = 1'b1;
          state_d           = HZ_RUN;
        end
      end
      default: state_d = HZ_RUN;
    endcase

    if (run_rules) begin
      state_d = HZ_RUN;
      if (mem_busy) begin
        pc_stall = 1'b1;
        stall    = '1;
        state_d  = HZ_WAIT;
        if (hz.redirect_i) begin
          pend_tgt_d = hz.redirect_tgt_i;
          state_d    = HZ_PEND;
        end
      end else if (hz.redirect_i) begin
        pc_redirect       = 1'b1;
        flush[PREG_IF_ID] = 1'b1;
        flush[PREG_ID_EX] = 1'b1;
      end else if (load_use) begin
        pc_stall          = 1'b1;
        stall[PREG_IF_ID] = 1'b1;
        flush[PREG_ID_EX] = 1'b1;
      end
    end
  end

  always_comb begin
    timeout_d = timeout_q;
    if (mem_busy && (wait_cnt == WAIT_W'(TIMEOUT - 1))) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HZ_RUN;
      pend_tgt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Combinational controls are forced quiet while reset is asserted.
  assign hz.pc_stall_o    = rst_n & pc_stall;
  assign hz.pc_redirect_o = rst_n & pc_redirect;
  assign hz.pc_tgt_o      = rst_n ? pc_tgt : '0;
  assign hz.stall_o       = rst_n ? stall : '0;
  assign hz.flush_o       = rst_n ? flush : '0;
  assign hz.timeout_o     = timeout_q;

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!mem_busy),
    .inc   (mem_busy),
    .cnt_o (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (hz.pc_stall_o),
    .cnt_o (hz.stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (hz.pc_redirect_o),
    .cnt_o (hz.flush_cnt_o)
  );
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: default-parameter unit and a TIMEOUT=4 / CNT_W=2 unit share one stimulus.
module tb_hazard_ctrl_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, ex_rd;
  logic        use1, use2, ex_ld, redir, imw, dmw;
  logic [31:0] tgt;

  int n_checks = 0;
  int n_errs   = 0;

  hazard_ctrl_unit_if #(.NUM_PREG(4), .REG_AW(5), .PC_W(32), .CNT_W(16)) if0 ();
  hazard_ctrl_unit_if #(.NUM_PREG(4), .REG_AW(5), .PC_W(32), .CNT_W(2))  if1 ();

  assign if0.id_rs1_i = rs1;    assign if1.id_rs1_i = rs1;
  assign if0.id_rs2_i = rs2;    assign if1.id_rs2_i = rs2;
  assign if0.id_use_rs1_i = use1; assign if1.id_use_rs1_i = use1;
  assign if0.id_use_rs2_i = use2; assign if1.id_use_rs2_i = use2;
  assign if0.ex_rd_i = ex_rd;   assign if1.ex_rd_i = ex_rd;
  assign if0.ex_mem_rd_i = ex_ld; assign if1.ex_mem_rd_i = ex_ld;
  assign if0.redirect_i = redir; assign if1.redirect_i = redir;
  assign if0.redirect_tgt_i = tgt; assign if1.redirect_tgt_i = tgt;
  assign if0.im_wait_i = imw;   assign if1.im_wait_i = imw;
  assign if0.dm_wait_i = dmw;   assign if1.dm_wait_i = dmw;

  hazard_ctrl_unit #(.NUM_PREG(4), .REG_AW(5), .PC_W(32), .CNT_W(16), .TIMEOUT(255)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if0)
  );

  hazard_ctrl_unit #(.NUM_PREG(4), .REG_AW(5), .PC_W(32), .CNT_W(2), .TIMEOUT(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; ex_rd = '0; use1 = 0; use2 = 0; ex_ld = 0;
    redir = 0; tgt = '0; imw = 0; dmw = 0;
  endtask

  task automatic load_use5();
    ex_ld = 1; ex_rd = 5'd5; rs1 = 5'd5; use1 = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    redir = 1; tgt = 32'hdead_beef; ex_ld = 1; ex_rd = 5'd3; rs1 = 5'd3; use1 = 1;
    #2;
    chk("rst_redirect", if0.pc_redirect_o, 0);
    chk("rst_tgt",      if0.pc_tgt_o, 0);
    chk("rst_flush",    if0.flush_o, 0);
    chk("rst_pcstall",  if0.pc_stall_o, 0);
    chk("rst_scnt",     if0.stall_cnt_o, 0);
    chk("rst_fcnt",     if0.flush_cnt_o, 0);
    chk("rst_timeout",  if1.timeout_o, 0);
    idle();
    tick(); tick();
    rst_n = 1;

    // single load-use bubble on rs1
    load_use5(); #2;
    chk("lu_pcstall", if0.pc_stall_o, 1);
    chk("lu_stall",   if0.stall_o, 4'b0001);
    chk("lu_flush",   if0.flush_o, 4'b0010);
    chk("lu_redir",   if0.pc_redirect_o, 0);
    tick();
    idle(); #2;
    chk("lu_one_cycle", if0.pc_stall_o, 0);
    chk("lu_scnt",      if0.stall_cnt_o, 1);
    tick();

    // load into x0 never stalls
    ex_ld = 1; ex_rd = 5'd0; rs1 = 5'd0; use1 = 1; #2;
    chk("x0_pcstall", if0.pc_stall_o, 0);
    chk("x0_flush",   if0.flush_o, 0);
    tick();

    // rs2 match; rs1 matches too but is not used
    idle(); ex_ld = 1; ex_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7; use2 = 1; #2;
    chk("rs2_stall", if0.stall_o, 4'b0001);
    tick();

    idle(); ex_ld = 1; ex_rd = 5'd9; rs1 = 5'd9; rs2 = 5'd9; #2;
    chk("nouse_pcstall", if0.pc_stall_o, 0);
    tick();

    // redirect overrides load-use
    idle(); load_use5(); redir = 1; tgt = 32'h0000_0100; #2;
    chk("rd_redir",   if0.pc_redirect_o, 1);
    chk("rd_tgt",     if0.pc_tgt_o, 32'h100);
    chk("rd_flush",   if0.flush_o, 4'b0011);
    chk("rd_pcstall", if0.pc_stall_o, 0);
    chk("rd_stall",   if0.stall_o, 0);
    tick();
    idle(); #2;
    chk("rd_fcnt", if0.flush_cnt_o, 1);
    chk("rd_scnt", if0.stall_cnt_o, 2);
    tick();

    // redirect arriving during a data-memory wait is deferred
    dmw = 1; #2;
    chk("dw1_stall", if0.stall_o, 4'b1111);
    chk("dw1_pcst",  if0.pc_stall_o, 1);
    chk("dw1_flush", if0.flush_o, 0);
    tick();
    redir = 1; tgt = 32'h200; #2;
    chk("dw2_stall", if0.stall_o, 4'b1111);
    chk("dw2_redir", if0.pc_redirect_o, 0);
    tick();
    tgt = 32'h300; #2;
    chk("dw3_stall", if0.stall_o, 4'b1111);
    chk("dw3_redir", if0.pc_redirect_o, 0);
    chk("dw3_flush", if0.flush_o, 0);
    tick();
    dmw = 0; #2;
    chk("pend_redir",   if0.pc_redirect_o, 1);
    chk("pend_tgt",     if0.pc_tgt_o, 32'h200);
    chk("pend_flush",   if0.flush_o, 4'b0011);
    chk("pend_stall",   if0.stall_o, 0);
    chk("pend_pcstall", if0.pc_stall_o, 0);
    tick();
    idle(); #2;
    chk("pend_done",   if0.pc_redirect_o, 0);
    chk("dw_fcnt",     if0.flush_cnt_o, 2);
    chk("dw_scnt",     if0.stall_cnt_o, 5);
    chk("dw_scnt_sat", if1.stall_cnt_o, 3);
    chk("dw_no_to",    if1.timeout_o, 0);
    tick();

    // leaving WAIT applies the RUN rules in the same cycle
    dmw = 1; #2;
    tick();
    dmw = 0; redir = 1; tgt = 32'h500; #2;
    chk("wx_redir", if0.pc_redirect_o, 1);
    chk("wx_tgt",   if0.pc_tgt_o, 32'h500);
    chk("wx_flush", if0.flush_o, 4'b0011);
    tick();

    // watchdog: six busy cycles against TIMEOUT=4
    idle(); imw = 1;
    for (int i = 0; i < 6; i++) begin
      #2;
      if (i == 3) chk("to_before", if1.timeout_o, 0);
      if (i == 4) chk("to_set",    if1.timeout_o, 1);
      tick();
    end
    idle(); #2;
    chk("to_sticky",  if1.timeout_o, 1);
    chk("to_dflt",    if0.timeout_o, 0);
    chk("to_scnt",    if0.stall_cnt_o, 12);
    tick();
    #2;
    chk("to_sticky2", if1.timeout_o, 1);
    rst_n = 0; #1;
    chk("to_cleared", if1.timeout_o, 0);
    chk("rst_scnt1",  if1.stall_cnt_o, 0);
    tick();
    rst_n = 1;

    // five load-use bubbles saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      load_use5(); #2;
      tick();
    end
    idle(); #2;
    chk("sat_scnt1", if1.stall_cnt_o, 3);
    chk("sat_scnt0", if0.stall_cnt_o, 5);
    tick();

    // reset during PEND drops the pending redirect
    dmw = 1; redir = 1; tgt = 32'h400; #2;
    tick();
    redir = 0; #2;
    chk("pr_stall", if0.stall_o, 4'b1111);
    rst_n = 0; #1;
    chk("pr_rst_redir",   if0.pc_redirect_o, 0);
    chk("pr_rst_stall",   if0.stall_o, 0);
    chk("pr_rst_pcstall", if0.pc_stall_o, 0);
    chk("pr_rst_tgt",     if0.pc_tgt_o, 0);
    tick();
    idle(); rst_n = 1; #2;
    chk("pr_dropped", if0.pc_redirect_o, 0);
    chk("pr_flush",   if0.flush_o, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
